// File: rtl/datapath_pipe.sv
// Five-stage LEGv8 pipeline (IF, ID, EX, MEM, WB) with write-through register file, branch flush and optional load-use stall.
// Latency: an instruction latched into IF/ID at edge t writes back at edge t+4; a taken branch costs 3 cycles.
// Backpressure: none externally; with DATAPATH_FORWARDING_EN a load-use hazard holds PC and IF/ID for one cycle.
//
// Ports: clk, reset (sync, active-high); ID-stage control inputs from the external control unit
// (reg2loc, AluSrc, Branch, memRead, memWrite, regWrite, memtoReg, Uncondbranch, BranchSrc, AluControl);
// instruction memory IM_addr/IM_readData; data memory DM_addr/DM_writeData/DM_readData/DM_writeEnable/DM_readEnable;
// instr_ID feeds the control unit.
// Build option: define DATAPATH_FORWARDING_EN for EX operand forwarding plus load-use stall.
module datapath_pipe #(
    parameter int           N        = 64,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reg2loc,
    input  logic         AluSrc,
    input  logic         Branch,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic         regWrite,
    input  logic         memtoReg,
    input  logic         Uncondbranch,
    input  logic         BranchSrc,
    input  logic [3:0]   AluControl,
    input  logic [31:0]  IM_readData,
    input  logic [N-1:0] DM_readData,
    output logic [31:0]  instr_ID,
    output logic [N-1:0] IM_addr,
    output logic [N-1:0] DM_addr,
    output logic [N-1:0] DM_writeData,
    output logic         DM_writeEnable,
    output logic         DM_readEnable
);

    typedef struct packed {
        logic       alu_src;
        logic       branch;
        logic       uncond;
        logic       branch_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

    logic [N-1:0] rf [0:31];

    // IF
    logic [N-1:0] pc;
    // IF/ID
    logic [31:0]  d_instr;
    logic [N-1:0] d_pc;
    // ID/EX
    ctrl_t        e_ctrl;
    logic [N-1:0] e_pc, e_rd1, e_rd2, e_imm;
    logic [4:0]   e_rd;
`ifdef DATAPATH_FORWARDING_EN
    logic [4:0]   e_rn, e_r2;
`endif
    // EX/MEM
    logic         m_branch, m_uncond, m_rd_en, m_wr_en, m_reg_write, m_mem_to_reg, m_zero;
    logic [N-1:0] m_alu, m_sdata, m_target;
    logic [4:0]   m_rd;
    // MEM/WB
    logic         w_reg_write, w_mem_to_reg;
    logic [N-1:0] w_alu, w_mdata;
    logic [4:0]   w_rd;

    // ---------------- ID ----------------
    ctrl_t        d_ctrl;
    logic [4:0]   d_rn, d_r2;
    logic [N-1:0] d_rd1, d_rd2, d_imm;
    logic         w_we;
    logic [N-1:0] w_data;

    assign d_rn   = d_instr[9:5];
    assign d_r2   = reg2loc ? d_instr[4:0] : d_instr[20:16];
    assign w_we   = w_reg_write && (w_rd != 5'd31);
    assign w_data = w_mem_to_reg ? w_mdata : w_alu;

    always_comb begin
        d_ctrl            = '0;
        d_ctrl.alu_src    = AluSrc;
        d_ctrl.branch     = Branch;
        d_ctrl.uncond     = Uncondbranch;
        d_ctrl.branch_src = BranchSrc;
        d_ctrl.mem_read   = memRead;
        d_ctrl.mem_write  = memWrite;
        d_ctrl.reg_write  = regWrite;
        d_ctrl.mem_to_reg = memtoReg;
        d_ctrl.alu_op     = AluControl;
    end

    // X31 reads zero; a register being written back this cycle reads its new value.
    always_comb begin
        d_rd1 = rf[d_rn];
        d_rd2 = rf[d_r2];
        if (w_we && (w_rd == d_rn)) d_rd1 = w_data;
        if (w_we && (w_rd == d_r2)) d_rd2 = w_data;
        if (d_rn == 5'd31) d_rd1 = '0;
        if (d_r2 == 5'd31) d_rd2 = '0;
    end

    // Immediate by opcode. Arithmetic I-type (ADDI/SUBI family) zero-extends imm12 so
    // immediate ALU ops have an operand; anything unrecognised yields 0.
    always_comb begin
        d_imm = '0;
        if (d_instr[31:21] ==? 11'b111110000?0)
            d_imm = {{(N-9){d_instr[20]}}, d_instr[20:12]};
        else if (d_instr[31:22] ==? 10'b1??1000100)
            d_imm = {{(N-12){1'b0}}, d_instr[21:10]};
        else if ((d_instr[31:24] ==? 8'b1011010?) || (d_instr[31:24] == 8'b01010100))
            d_imm = {{(N-19){d_instr[23]}}, d_instr[23:5]};
        else if (d_instr[31:26] ==? 6'b?00101)
            d_imm = {{(N-26){d_instr[25]}}, d_instr[25:0]};
    end

    // ---------------- EX ----------------
    logic [N-1:0] e_opa, e_opb_reg, e_opb, e_alu, e_target;
    logic         e_zero;

`ifdef DATAPATH_FORWARDING_EN
    // EX/MEM result wins over MEM/WB; X31 is never a forwarding destination.
    always_comb begin
        e_opa     = e_rd1;
        e_opb_reg = e_rd2;
        if (m_reg_write && (m_rd != 5'd31) && (m_rd == e_rn)) e_opa = m_alu;
        else if (w_we && (w_rd == e_rn))                       e_opa = w_data;
        if (m_reg_write && (m_rd != 5'd31) && (m_rd == e_r2)) e_opb_reg = m_alu;
        else if (w_we && (w_rd == e_r2))                       e_opb_reg = w_data;
    end
`else
    assign e_opa     = e_rd1;
    assign e_opb_reg = e_rd2;
`endif

    assign e_opb = e_ctrl.alu_src ? e_imm : e_opb_reg;

    always_comb begin
        case (e_ctrl.alu_op)
            4'b0000: e_alu = e_opa & e_opb;
            4'b0001: e_alu = e_opa | e_opb;
            4'b0010: e_alu = e_opa + e_opb;
            4'b0110: e_alu = e_opa - e_opb;
            4'b0111: e_alu = e_opb;
            4'b1100: e_alu = ~(e_opa | e_opb);
            default: e_alu = '0;
        endcase
    end

    assign e_zero   = (e_alu == '0);
    assign e_target = e_ctrl.branch_src ? e_opa : (e_pc + (e_imm << 2));

    // ---------------- MEM ----------------
    logic pcsrc;
    assign pcsrc = m_uncond | (m_branch & m_zero);

    assign IM_addr        = pc;
    assign instr_ID       = d_instr;
    assign DM_addr        = m_alu;
    assign DM_writeData   = m_sdata;
    assign DM_writeEnable = m_wr_en;
    assign DM_readEnable  = m_rd_en;

    // ---------------- hazard ----------------
    logic stall;
`ifdef DATAPATH_FORWARDING_EN
    assign stall = e_ctrl.mem_read && (e_rd != 5'd31) && ((e_rd == d_rn) || (e_rd == d_r2));
`else
    assign stall = 1'b0;
`endif

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_RESET;
            d_instr      <= '0;
            d_pc         <= '0;
            e_ctrl       <= '0;
            e_pc         <= '0;
            e_rd1        <= '0;
            e_rd2        <= '0;
            e_imm        <= '0;
            e_rd         <= '0;
`ifdef DATAPATH_FORWARDING_EN
            e_rn         <= '0;
            e_r2         <= '0;
`endif
            m_branch     <= 1'b0;
            m_uncond     <= 1'b0;
            m_rd_en      <= 1'b0;
            m_wr_en      <= 1'b0;
            m_reg_write  <= 1'b0;
            m_mem_to_reg <= 1'b0;
            m_zero       <= 1'b0;
            m_alu        <= '0;
            m_sdata      <= '0;
            m_target     <= '0;
            m_rd         <= '0;
            w_reg_write  <= 1'b0;
            w_mem_to_reg <= 1'b0;
            w_alu        <= '0;
            w_mdata      <= '0;
            w_rd         <= '0;
        end else begin
            // A taken branch outranks the stall: PC takes the target and IF/ID becomes a NOP.
            if (pcsrc)       pc <= m_target;
            else if (!stall) pc <= pc + PC_STEP;

            if (pcsrc) begin
                d_instr <= '0;
                d_pc    <= pc;
            end else if (!stall) begin
                d_instr <= IM_readData;
                d_pc    <= pc;
            end

            // Data fields always advance; only control is squashed on flush or stall.
            e_ctrl <= (pcsrc || stall) ? '0 : d_ctrl;
            e_pc   <= d_pc;
            e_rd1  <= d_rd1;
            e_rd2  <= d_rd2;
            e_imm  <= d_imm;
            e_rd   <= d_instr[4:0];
`ifdef DATAPATH_FORWARDING_EN
            e_rn   <= d_rn;
            e_r2   <= d_r2;
`endif

            m_branch     <= pcsrc ? 1'b0 : e_ctrl.branch;
            m_uncond     <= pcsrc ? 1'b0 : e_ctrl.uncond;
            m_rd_en      <= pcsrc ? 1'b0 : e_ctrl.mem_read;
            m_wr_en      <= pcsrc ? 1'b0 : e_ctrl.mem_write;
            m_reg_write  <= pcsrc ? 1'b0 : e_ctrl.reg_write;
            m_mem_to_reg <= pcsrc ? 1'b0 : e_ctrl.mem_to_reg;
            m_zero       <= e_zero;
            m_alu        <= e_alu;
            m_sdata      <= e_opb_reg;
            m_target     <= e_target;
            m_rd         <= e_rd;

            // The branch in MEM itself still retires.
            w_reg_write  <= m_reg_write;
            w_mem_to_reg <= m_mem_to_reg;
            w_alu        <= m_alu;
            w_mdata      <= DM_readData;
            w_rd         <= m_rd;
        end
    end

    // Register contents survive reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && w_we) rf[w_rd] <= w_data;
    end

endmodule
